// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the load/store access sequencer:
//   - state_t : FSM state encoding (IDLE=00, REQ=01, RESP=10)
//   - F3_*    : funct3 access-width codes
//   - f3_legal: true for the five access widths the unit supports
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Data-memory request/acknowledge bus.
//   bus_req   : request, held until ack or abort
//   bus_we    : 1 = write
//   bus_addr  : word-aligned byte address
//   bus_be    : byte-lane enables
//   bus_wdata : lane-replicated store data
//   bus_ack   : single-cycle acknowledge (read data valid same cycle)
//   bus_rdata : read data word
// master = access unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the access sequencer.
//   i_funct3     : access width code
//   i_addr_lo    : byte offset within the word
//   i_wdata      : raw store data (rs2)
//   i_rdata_word : raw read word from the bus
//   o_be         : byte enables for the access
//   o_wdata      : store data replicated across the lanes
//   o_rdata      : load data shifted down and sign/zero extended
//   o_aligned    : legal width and naturally aligned offset
// ---------------------------------------------------------------------------
module lsu_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_aligned
);

    logic [31:0] w_shifted;

    always_comb begin
        // Bring the addressed byte/halfword down to bit 0.
        w_shifted = i_rdata_word >> {i_addr_lo, 3'b000};
        o_be      = 4'b0000;
        o_wdata   = 32'h0;
        o_rdata   = 32'h0;
        o_aligned = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be      = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_wdata[7:0]}};
                o_rdata   = (i_funct3 == F3_B) ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                               : {24'h0, w_shifted[7:0]};
                o_aligned = 1'b1;
            end
            F3_H, F3_HU: begin
                o_be      = 4'b0011 << i_addr_lo;
                o_wdata   = {2{i_wdata[15:0]}};
                o_rdata   = (i_funct3 == F3_H) ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                               : {16'h0, w_shifted[15:0]};
                o_aligned = ~i_addr_lo[0];
            end
            F3_W: begin
                o_be      = 4'b1111;
                o_wdata   = i_wdata;
                o_rdata   = i_rdata_word;
                o_aligned = (i_addr_lo == 2'b00);
            end
            default: begin
                o_aligned = 1'b0;
            end
        endcase
        // Illegal widths never reach the bus; keep the check explicit.
        o_aligned = o_aligned & f3_legal(i_funct3);
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store access sequencer. Accepts mem_read/mem_write strobes with the
// ALU address and rs2 data, runs one request/ack transaction on the data
// bus, and holds the pipeline with stall until done, misalign or timeout.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mem_read, mem_write : access strobes (write wins when both set)
//   funct3, addr, wdata : width code, byte address, store data
//   stall               : pipeline hold (combinational)
//   rdata, done         : extended load result and completion pulse
//   misalign_err        : misaligned address or illegal width
//   timeout_err         : no ack within TIMEOUT cycles
//   bus                 : data-memory bus (master side)
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic                     stall,
    output logic [31:0]              rdata,
    output logic                     done,
    output logic                     misalign_err,
    output logic                     timeout_err,
    mem_access_unit_if.master        bus
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [2:0]    r_f3, w_f3_next;
    logic [1:0]    r_addr_lo, w_addr_lo_next;
    logic          r_bus_req, w_bus_req_next;
    logic          r_bus_we, w_bus_we_next;
    logic [31:0]   r_bus_addr, w_bus_addr_next;
    logic [3:0]    r_bus_be, w_bus_be_next;
    logic [31:0]   r_bus_wdata, w_bus_wdata_next;
    logic [31:0]   r_rdata, w_rdata_next;
    logic          r_mis, w_mis_next;
    logic          r_tmo, w_tmo_next;

    logic          w_idle;
    logic          w_access;
    logic [2:0]    w_sel_f3;
    logic [1:0]    w_sel_lo;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_ld_data;
    logic          w_aligned;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_access = mem_read | mem_write;

    // One lane block serves both phases: in IDLE it checks and steers the
    // incoming request, in REQ it extends the returning word using the
    // latched width and offset.
    assign w_sel_f3 = w_idle ? funct3     : r_f3;
    assign w_sel_lo = w_idle ? addr[1:0]  : r_addr_lo;

    lsu_align u_align (
        .i_funct3     (w_sel_f3),
        .i_addr_lo    (w_sel_lo),
        .i_wdata      (wdata),
        .i_rdata_word (bus.bus_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata_rep),
        .o_rdata      (w_ld_data),
        .o_aligned    (w_aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_f3        <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'h0;
            r_rdata     <= 32'h0;
            r_mis       <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_f3        <= w_f3_next;
            r_addr_lo   <= w_addr_lo_next;
            r_bus_req   <= w_bus_req_next;
            r_bus_we    <= w_bus_we_next;
            r_bus_addr  <= w_bus_addr_next;
            r_bus_be    <= w_bus_be_next;
            r_bus_wdata <= w_bus_wdata_next;
            r_rdata     <= w_rdata_next;
            r_mis       <= w_mis_next;
            r_tmo       <= w_tmo_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_f3_next        = r_f3;
        w_addr_lo_next   = r_addr_lo;
        w_bus_req_next   = r_bus_req;
        w_bus_we_next    = r_bus_we;
        w_bus_addr_next  = r_bus_addr;
        w_bus_be_next    = r_bus_be;
        w_bus_wdata_next = r_bus_wdata;
        w_rdata_next     = r_rdata;
        w_mis_next       = r_mis;
        w_tmo_next       = r_tmo;

        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_rdata_next = 32'h0;
                    w_tmo_next   = 1'b0;
                    if (w_aligned) begin
                        w_f3_next        = funct3;
                        w_addr_lo_next   = addr[1:0];
                        w_bus_req_next   = 1'b1;
                        w_bus_we_next    = mem_write;
                        w_bus_addr_next  = {addr[31:2], 2'b00};
                        w_bus_be_next    = w_be;
                        w_bus_wdata_next = w_wdata_rep;
                        w_cnt_next       = '0;
                        w_mis_next       = 1'b0;
                        w_state_next     = ST_REQ;
                    end else begin
                        w_mis_next   = 1'b1;
                        w_state_next = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (bus.bus_ack || (r_cnt == CNT_LAST)) begin
                    // Ack wins over a simultaneous timeout on the last cycle.
                    w_rdata_next     = (bus.bus_ack && !r_bus_we) ? w_ld_data : 32'h0;
                    w_tmo_next       = ~bus.bus_ack;
                    w_bus_req_next   = 1'b0;
                    w_bus_we_next    = 1'b0;
                    w_bus_addr_next  = 32'h0;
                    w_bus_be_next    = 4'b0000;
                    w_bus_wdata_next = 32'h0;
                    w_state_next     = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                w_rdata_next = 32'h0;
                w_mis_next   = 1'b0;
                w_tmo_next   = 1'b0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Result and flag registers are only non-zero during RESP.
    assign done          = (r_state == ST_RESP);
    assign rdata         = r_rdata;
    assign misalign_err  = r_mis;
    assign timeout_err   = r_tmo;

    assign stall = rst_n & ((w_idle & w_access) | (r_state == ST_REQ));

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_be    = r_bus_be;
    assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        misalign_err;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .rdata        (rdata),
        .done         (done),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, outputs are sampled
    // 1 unit later; both are well clear of the active edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        mem_read = 1'b0; mem_write = 1'b0; bus_if.bus_ack = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 1'b1; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        next_cycle();
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall); end
        total++; if (bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", bus_if.bus_req); end
        total++; if ({done, misalign_err, timeout_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {done, misalign_err, timeout_err}); end
        total++; if ({rdata, bus_if.bus_addr, bus_if.bus_wdata} !== 96'h0) begin bad++; $display("FAIL reset_data got %h %h %h want 0", rdata, bus_if.bus_addr, bus_if.bus_wdata); end
        total++; if ({bus_if.bus_be, bus_if.bus_we} !== 5'b0) begin bad++; $display("FAIL reset_be_we got %b want 00000", {bus_if.bus_be, bus_if.bus_we}); end
        mem_read = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        $display("reset: released");
    endtask

    task automatic test_lb();
        next_cycle();
        mem_read = 1'b1; funct3 = 3'b000; addr = 32'h103;
        #1;
        total++; if ({stall, bus_if.bus_req} !== 2'b10) begin bad++; $display("FAIL lb_c0 stall/req got %b want 10", {stall, bus_if.bus_req}); end
        next_cycle();
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h8000_0000;
        #1;
        total++; if (bus_if.bus_req !== 1'b1) begin bad++; $display("FAIL lb_req got %b want 1", bus_if.bus_req); end
        total++; if (bus_if.bus_addr !== 32'h100) begin bad++; $display("FAIL lb_addr got %h want 00000100", bus_if.bus_addr); end
        total++; if (bus_if.bus_be !== 4'b1000) begin bad++; $display("FAIL lb_be got %b want 1000", bus_if.bus_be); end
        total++; if (bus_if.bus_we !== 1'b0) begin bad++; $display("FAIL lb_we got %b want 0", bus_if.bus_we); end
        next_cycle();
        bus_if.bus_ack = 1'b0; mem_read = 1'b0;
        #1;
        total++; if ({done, misalign_err, timeout_err, stall} !== 4'b1000) begin bad++; $display("FAIL lb_done got %b want 1000", {done, misalign_err, timeout_err, stall}); end
        total++; if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got %h want ffffff80", rdata); end
        next_cycle();
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL lb_done_pulse got %b want 0", done); end
        $display("LB addr=00000103 rdata=%h", rdata);
        go_idle();
    endtask

    task automatic test_sh();
        int stall_cnt = 0;
        int done_cyc = -1;
        next_cycle();
        mem_write = 1'b1; funct3 = 3'b001; addr = 32'h202; wdata = 32'h1234_ABCD;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cycle();
            bus_if.bus_ack = (c == 4);
            #1;
            if (stall) stall_cnt++;
            if (c == 1) begin
                total++; if (bus_if.bus_be !== 4'b1100) begin bad++; $display("FAIL sh_be got %b want 1100", bus_if.bus_be); end
                total++; if (bus_if.bus_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata got %h want abcdabcd", bus_if.bus_wdata); end
                total++; if ({bus_if.bus_we, bus_if.bus_req} !== 2'b11) begin bad++; $display("FAIL sh_we_req got %b want 11", {bus_if.bus_we, bus_if.bus_req}); end
                total++; if (bus_if.bus_addr !== 32'h200) begin bad++; $display("FAIL sh_addr got %h want 00000200", bus_if.bus_addr); end
            end
            if (done && done_cyc < 0) begin
                done_cyc = c;
                total++; if (rdata !== 32'h0) begin bad++; $display("FAIL sh_rdata got %h want 0", rdata); end
                mem_write = 1'b0;
            end
        end
        total++; if (done_cyc !== 5) begin bad++; $display("FAIL sh_done_cycle got %0d want 5", done_cyc); end
        total++; if (stall_cnt !== 5) begin bad++; $display("FAIL sh_stall_cycles got %0d want 5", stall_cnt); end
        $display("SH addr=00000202 done_cycle=%0d stall_cycles=%0d", done_cyc, stall_cnt);
        go_idle();
    endtask

    task automatic test_misalign();
        logic [2:0]  f3s [2] = '{3'b010, 3'b011};
        logic [31:0] ads [2] = '{32'h006, 32'h000};
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            mem_read = 1'b1; funct3 = f3s[i]; addr = ads[i];
            #1;
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL mis%0d_stall got %b want 1", i, stall); end
            next_cycle();
            mem_read = 1'b0;
            #1;
            total++; if ({done, misalign_err, timeout_err} !== 3'b110) begin bad++; $display("FAIL mis%0d_flags got %b want 110", i, {done, misalign_err, timeout_err}); end
            total++; if ({bus_if.bus_req, rdata} !== 33'h0) begin bad++; $display("FAIL mis%0d_req_rdata got %b %h want 0 0", i, bus_if.bus_req, rdata); end
            $display("misalign funct3=%b addr=%h err=%b", f3s[i], ads[i], misalign_err);
            go_idle();
        end
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        int req_first = -1;
        int done_cyc = -1;
        logic [1:0] flags = 2'b00;
        next_cycle();
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h40; bus_if.bus_ack = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) next_cycle();
            #1;
            if (bus_if.bus_req) begin
                req_cnt++;
                if (req_first < 0) req_first = c;
            end
            if (done && done_cyc < 0) begin
                done_cyc = c;
                flags = {timeout_err, misalign_err};
                mem_read = 1'b0;
            end
        end
        total++; if (req_first !== 1) begin bad++; $display("FAIL tmo_req_first got %0d want 1", req_first); end
        total++; if (req_cnt !== 4) begin bad++; $display("FAIL tmo_req_cycles got %0d want 4", req_cnt); end
        total++; if (done_cyc !== 5) begin bad++; $display("FAIL tmo_done_cycle got %0d want 5", done_cyc); end
        total++; if (flags !== 2'b10) begin bad++; $display("FAIL tmo_flags got %b want 10", flags); end
        $display("timeout req_cycles=%0d done_cycle=%0d", req_cnt, done_cyc);
        go_idle();
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4] = '{3'b101, 3'b001, 3'b100, 3'b010};
        logic [31:0] ads [4] = '{32'h002, 32'h002, 32'h001, 32'h008};
        logic [31:0] wrd [4] = '{32'hF00D_0000, 32'hF00D_0000, 32'h0000_AB00, 32'hCAFE_BABE};
        logic [31:0] exp [4] = '{32'h0000_F00D, 32'hFFFF_F00D, 32'h0000_00AB, 32'hCAFE_BABE};
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            mem_read = 1'b1; funct3 = f3s[i]; addr = ads[i];
            next_cycle();
            bus_if.bus_ack = 1'b1; bus_if.bus_rdata = wrd[i];
            next_cycle();
            bus_if.bus_ack = 1'b0; mem_read = 1'b0;
            #1;
            total++; if ({done, rdata} !== {1'b1, exp[i]}) begin bad++; $display("FAIL ld%0d got done=%b rdata=%h want done=1 rdata=%h", i, done, rdata, exp[i]); end
            $display("load funct3=%b addr=%h rdata=%h", f3s[i], ads[i], rdata);
            go_idle();
        end
    endtask

    task automatic test_both_strobes();
        next_cycle();
        mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h10; wdata = 32'hDEAD_BEEF;
        next_cycle();
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h5555_5555;
        #1;
        total++; if ({bus_if.bus_we, bus_if.bus_be} !== 5'b11111) begin bad++; $display("FAIL both_we_be got %b want 11111", {bus_if.bus_we, bus_if.bus_be}); end
        total++; if (bus_if.bus_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL both_wdata got %h want deadbeef", bus_if.bus_wdata); end
        next_cycle();
        bus_if.bus_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        total++; if ({done, rdata} !== 33'h1_0000_0000) begin bad++; $display("FAIL both_done got done=%b rdata=%h want done=1 rdata=0", done, rdata); end
        $display("read+write strobes -> write, we=1");
        go_idle();
    endtask

    task automatic test_reset_mid_req();
        int done_seen = 0;
        int req_seen = 0;
        next_cycle();
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h20; bus_if.bus_ack = 1'b0;
        next_cycle();
        #1;
        total++; if (bus_if.bus_req !== 1'b1) begin bad++; $display("FAIL rstmid_req_before got %b want 1", bus_if.bus_req); end
        next_cycle();
        rst_n = 1'b0; mem_read = 1'b0;
        #1;
        total++; if ({bus_if.bus_req, stall} !== 2'b00) begin bad++; $display("FAIL rstmid_drop got %b want 00", {bus_if.bus_req, stall}); end
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            bus_if.bus_ack = (c == 0); bus_if.bus_rdata = 32'h1234_5678;
            #1;
            if (done) done_seen++;
            if (bus_if.bus_req) req_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL rstmid_done got %0d pulses want 0", done_seen); end
        total++; if (req_seen !== 0) begin bad++; $display("FAIL rstmid_req_after got %0d cycles want 0", req_seen); end
        $display("reset during REQ: abandoned");
        go_idle();
    endtask

    task automatic test_back_to_back();
        next_cycle();
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h30;
        next_cycle();
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1111_1111;
        #1;
        total++; if (bus_if.bus_addr !== 32'h30) begin bad++; $display("FAIL b2b_addr0 got %h want 00000030", bus_if.bus_addr); end
        next_cycle();
        bus_if.bus_ack = 1'b0; addr = 32'h34;
        #1;
        total++; if ({done, rdata} !== {1'b1, 32'h1111_1111}) begin bad++; $display("FAIL b2b_done0 got done=%b rdata=%h want done=1 rdata=11111111", done, rdata); end
        next_cycle();
        #1;
        total++; if ({stall, bus_if.bus_req, done} !== 3'b100) begin bad++; $display("FAIL b2b_idle got %b want 100", {stall, bus_if.bus_req, done}); end
        next_cycle();
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h2222_2222;
        #1;
        total++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h34}) begin bad++; $display("FAIL b2b_req1 got req=%b addr=%h want req=1 addr=00000034", bus_if.bus_req, bus_if.bus_addr); end
        next_cycle();
        bus_if.bus_ack = 1'b0; mem_read = 1'b0;
        #1;
        total++; if ({done, rdata} !== {1'b1, 32'h2222_2222}) begin bad++; $display("FAIL b2b_done1 got done=%b rdata=%h want done=1 rdata=22222222", done, rdata); end
        $display("back-to-back LW 00000030/00000034 completed");
        go_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        test_reset();
        test_lb();
        test_sh();
        test_misalign();
        test_timeout();
        test_load_ext();
        test_both_strobes();
        test_reset_mid_req();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access sequencer for the RISC-V core. It consumes the `mem_read`/`mem_write` strobes from the control decoder, together with the ALU address and rs2 data. It runs a request/acknowledge transaction on the data-memory bus with byte-lane steering and sign/zero extension, and holds the pipeline via `stall` until the access completes, faults on misalignment, or times out.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles to wait for `bus_ack` in REQ before aborting; must be ≥ 1.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  load request from the control decoder.
- `mem_write`  in  1  store request from the control decoder; wins if both are high.
- `funct3`  in  3  access width: 000 B, 001 H, 010 W, 100 BU, 101 HU. 011/110/111 are illegal.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2).
- `stall`  out  1  pipeline hold.
- `rdata`  out  32  extended load result; valid when `done`=1.
- `done`  out  1  one-cycle completion pulse.
- `misalign_err`  out  1  pulse with `done`: misaligned address or illegal funct3.
- `timeout_err`  out  1  pulse with `done`: no `bus_ack` within TIMEOUT cycles.
- `bus_req`  out  1  registered bus request, held until ack or timeout.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  single-cycle acknowledge; read data valid in the same cycle.
- `bus_rdata`  in  32  read data word.

## Operation
- The FSM has three states.
  - IDLE: no request → stay. Request with legal width and aligned address → latch `addr`, `wdata`, `funct3`, `we`, then go to REQ. Request with illegal funct3 or misaligned address → go to RESP with the misalign flag set.
- Alignment rule: H/HU/SH need `addr[0]`=0. W/SW need `addr[1:0]`=0. B is always aligned.
- REQ: `bus_req`=1 and bus outputs are driven from the latched values.
  - `bus_ack`=1 → capture `bus_rdata`, go to RESP.
  - Otherwise the wait counter increments. When it reaches TIMEOUT-1 with no ack → go to RESP with the timeout flag set; `bus_req` drops on entry to RESP.
- RESP: assert `done` plus the latched error flag; `rdata` is driven. Always go to IDLE next cycle.
- Byte enables: B = `4'b0001<<addr[1:0]`; H = `4'b0011<<addr[1:0]`; W = `4'b1111`.
- Store data: B replicates `wdata[7:0]` ×4; H replicates `wdata[15:0]` ×2; W passes through.
- Load data: shift the word right by `8*addr[1:0]`, then:
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - W is unchanged.
- `rdata` is 0 on any error and for stores.
- `stall` = (IDLE and (`mem_read`|`mem_write`)) or REQ. It is combinational and low in RESP, so the pipeline advances at the end of the RESP cycle.
- `bus_ack` outside REQ is ignored.
- Counter width is `$clog2(TIMEOUT+1)`; it clears on REQ entry and never wraps.

## Timing
- Reset: asynchronous return to IDLE. Counter = 0. `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`, `rdata`, `done`, both error flags = 0. `stall` is forced to 0 while `rst_n`=0.
- Reset mid-REQ: `bus_req` falls asynchronously and the transaction is abandoned; no `done` is issued.
- Latency with request at cycle 0 and `bus_ack` high at cycle 1: REQ in cycle 1, `done` in cycle 2. Each extra wait cycle adds 1.
- Error latency: `done`+`misalign_err` in cycle 1.
- Timeout: REQ lasts exactly TIMEOUT cycles, with `done`+`timeout_err` in the following cycle.
- Throughput: one access per 3 cycles minimum (back-to-back requests re-enter REQ from IDLE).

## Structure
- Shared `defines.v` gains the funct3 width codes (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the 2-bit state encodings (IDLE=00, REQ=01, RESP=10).
- One combinational sub-module, `lsu_align`: byte-enable generation, store-lane replication, load shift/extend, and the alignment check. The FSM and counter stay in `mem_access_unit`.

## Test plan
- LB from `addr`=0x103, `bus_rdata`=0x80_00_00_00, ack in cycle 1 → `done` in cycle 2, `rdata`=0xFFFF_FF80, `bus_be`=1000, `bus_addr`=0x100.
- SH `addr`=0x202, `wdata`=0x1234_ABCD, ack after 3 wait cycles → `bus_be`=1100, `bus_wdata`=0xABCD_ABCD, `bus_we`=1, `stall` high 5 cycles, `done` at cycle 5.
- LW `addr`=0x006 → no `bus_req`, `done`+`misalign_err` at cycle 1, `rdata`=0. Illegal funct3 011 gives the same response.
- TIMEOUT=4, `bus_ack` held 0 → `bus_req` high for exactly cycles 1–4, `done`+`timeout_err` at cycle 5.
- LHU `addr`=0x002, `bus_rdata`=0xF00D_0000 → `rdata`=0x0000_F00D. Both `mem_read` and `mem_write` high → write transaction.
- `rst_n` pulsed low in cycle 2 of a waiting REQ → `bus_req`/`stall` drop immediately, and a later ack produces no `done`.
